// File: rtl/simple_bus_pkg.sv
// Shared helpers for the simple_bus interconnect.
// Select-width function and the unmapped-device sentinel.
// Pure compile-time content, no logic.
package simple_bus_pkg;

    // Width needed to index n items, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Device index used to mark an address that matched no device.
    function automatic int unsigned unmapped_dev(input int unsigned nr_devices);
        return nr_devices;
    endfunction

endpackage

// File: rtl/simple_bus_arb.sv
// Fixed-priority arbiter: lowest set index wins, one-hot plus binary index out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; losers are simply not selected this cycle.
module simple_bus_arb #(
    parameter int unsigned N    = 1,
    parameter int unsigned IdxW = 1
) (
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] idx,
    output logic            any
);

    // Scan upward and keep only the first requester.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (req[i] && !any) begin
                gnt[i] = 1'b1;
                idx    = IdxW'(i);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/simple_bus.sv
// Multi-host to multi-device req/gnt/rvalid bus with fixed-priority hosts and base/mask decode.
// Latency: grant and device req combinational; response routed back one cycle after grant.
// Backpressure: losing hosts see gnt=0 and hold; macro BUS_DECODE_ERR_EN selects error-response vs stall for unmapped addresses.
module simple_bus
    import simple_bus_pkg::*;
#(
    parameter int unsigned NrDevices    = 1,
    parameter int unsigned NrHosts      = 1,
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned AddressWidth = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,

    input  logic                      host_req_i     [NrHosts],
    input  logic                      host_we_i      [NrHosts],
    input  logic [AddressWidth-1:0]   host_addr_i    [NrHosts],
    input  logic [DataWidth/8-1:0]    host_be_i      [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i   [NrHosts],
    output logic                      host_gnt_o     [NrHosts],
    output logic                      host_rvalid_o  [NrHosts],
    output logic                      host_err_o     [NrHosts],
    output logic [DataWidth-1:0]      host_rdata_o   [NrHosts],

    output logic                      device_req_o   [NrDevices],
    output logic                      device_we_o    [NrDevices],
    output logic [AddressWidth-1:0]   device_addr_o  [NrDevices],
    output logic [DataWidth/8-1:0]    device_be_o    [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o [NrDevices],
    input  logic                      device_rvalid_i[NrDevices],
    input  logic                      device_err_i   [NrDevices],
    input  logic [DataWidth-1:0]      device_rdata_i [NrDevices],

    input  logic [AddressWidth-1:0]   cfg_device_addr_base[NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask[NrDevices]
);

    localparam int unsigned HostIdxW = clog2_min1(NrHosts);
    // One extra code point so the sentinel fits alongside real device indices.
    localparam int unsigned DevSelW  = clog2_min1(NrDevices + 1);
    localparam int unsigned Unmapped = unmapped_dev(NrDevices);

    logic [NrHosts-1:0]      host_req_vec;
    logic [NrHosts-1:0]      host_oh;
    logic [HostIdxW-1:0]     host_idx;
    logic                    host_any;

    logic [NrDevices-1:0]    dev_match;
    logic [NrDevices-1:0]    dev_oh;
    logic [DevSelW-1:0]      dev_idx;
    logic                    dev_any;

    logic                    win_we;
    logic [AddressWidth-1:0] win_addr;
    logic [DataWidth/8-1:0]  win_be;
    logic [DataWidth-1:0]    win_wdata;

    logic                    accept;
    logic                    rsp_pend;
    logic [HostIdxW-1:0]     host_sel;
    logic [DevSelW-1:0]      dev_sel;

    logic                    rsp_vld;
    logic                    rsp_err;
    logic [DataWidth-1:0]    rsp_dat;

    // Flatten host requests for the arbiter.
    always_comb begin
        host_req_vec = '0;
        for (int h = 0; h < int'(NrHosts); h++) begin
            host_req_vec[h] = host_req_i[h];
        end
    end

    simple_bus_arb #(
        .N    (NrHosts),
        .IdxW (HostIdxW)
    ) u_host_arb (
        .req (host_req_vec),
        .gnt (host_oh),
        .idx (host_idx),
        .any (host_any)
    );

    // Select the winning host's request fields with the one-hot grant.
    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_be    = '0;
        win_wdata = '0;
        for (int h = 0; h < int'(NrHosts); h++) begin
            if (host_oh[h]) begin
                win_we    = host_we_i[h];
                win_addr  = host_addr_i[h];
                win_be    = host_be_i[h];
                win_wdata = host_wdata_i[h];
            end
        end
    end

    // Base/mask match of the winning address against every device window.
    always_comb begin
        dev_match = '0;
        for (int d = 0; d < int'(NrDevices); d++) begin
            dev_match[d] = ((win_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]);
        end
    end

    // Overlapping windows resolve to the lowest device index.
    simple_bus_arb #(
        .N    (NrDevices),
        .IdxW (DevSelW)
    ) u_dev_arb (
        .req (dev_match),
        .gnt (dev_oh),
        .idx (dev_idx),
        .any (dev_any)
    );

`ifdef BUS_DECODE_ERR_EN
    // Unmapped accesses are accepted and answered with an error next cycle.
    assign accept = host_any;
`else
    // Unmapped accesses are left ungranted so the host stalls.
    assign accept = host_any & dev_any;

    unmapped_stall: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(host_any && !dev_any));
`endif

    // Grant to the winner, req to the decoded device, request fields to everyone.
    always_comb begin
        for (int h = 0; h < int'(NrHosts); h++) begin
            host_gnt_o[h] = accept & host_oh[h];
        end
        for (int d = 0; d < int'(NrDevices); d++) begin
            device_req_o[d]   = accept & dev_oh[d];
            device_we_o[d]    = win_we;
            device_addr_o[d]  = win_addr;
            device_be_o[d]    = win_be;
            device_wdata_o[d] = win_wdata;
        end
    end

    // Remember who to route the next-cycle response between; reset drops it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_pend <= 1'b0;
            host_sel <= '0;
            dev_sel  <= '0;
        end else begin
            rsp_pend <= accept;
            if (accept) begin
                host_sel <= host_idx;
                dev_sel  <= dev_any ? dev_idx : DevSelW'(Unmapped);
            end
        end
    end

    // Pick the responding device (or synthesize the decode error) and steer to the host.
    always_comb begin
        rsp_vld = 1'b0;
        rsp_err = 1'b0;
        rsp_dat = '0;
        if (rsp_pend) begin
            for (int d = 0; d < int'(NrDevices); d++) begin
                if (dev_sel == DevSelW'(d)) begin
                    rsp_vld = device_rvalid_i[d];
                    rsp_err = device_err_i[d];
                    rsp_dat = device_rdata_i[d];
                end
            end
`ifdef BUS_DECODE_ERR_EN
            if (dev_sel == DevSelW'(Unmapped)) begin
                rsp_vld = 1'b1;
                rsp_err = 1'b1;
                rsp_dat = '0;
            end
`endif
        end
        for (int h = 0; h < int'(NrHosts); h++) begin
            host_rvalid_o[h] = 1'b0;
            host_err_o[h]    = 1'b0;
            host_rdata_o[h]  = '0;
            if (rsp_pend && (host_sel == HostIdxW'(h))) begin
                host_rvalid_o[h] = rsp_vld;
                host_err_o[h]    = rsp_err;
                host_rdata_o[h]  = rsp_dat;
            end
        end
    end

endmodule

// File: tb/tb_simple_bus.sv
// Scoreboard bench for simple_bus with two hosts and a RAM/SimCtrl/Timer map.
// Each request's expected response is queued when driven and popped one cycle later.
// Inputs change at posedge+1, outputs are sampled on the falling edge.
module tb_simple_bus;

    localparam int NH = 2;
    localparam int ND = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = DW + 2;

    logic clk;
    logic rst_n;

    logic            host_req   [NH];
    logic            host_we    [NH];
    logic [AW-1:0]   host_addr  [NH];
    logic [DW/8-1:0] host_be    [NH];
    logic [DW-1:0]   host_wdata [NH];
    logic            host_gnt   [NH];
    logic            host_rvalid[NH];
    logic            host_err   [NH];
    logic [DW-1:0]   host_rdata [NH];

    logic            device_req   [ND];
    logic            device_we    [ND];
    logic [AW-1:0]   device_addr  [ND];
    logic [DW/8-1:0] device_be    [ND];
    logic [DW-1:0]   device_wdata [ND];
    logic            device_rvalid[ND];
    logic            device_err   [ND];
    logic [DW-1:0]   device_rdata [ND];

    logic [AW-1:0]   cfg_base[ND];
    logic [AW-1:0]   cfg_mask[ND];

    logic [DW-1:0]   dev_data[ND];
    logic            dev_err [ND];

    typedef struct {
        int          host;
        logic [DW-1:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    simple_bus #(
        .NrDevices    (ND),
        .NrHosts      (NH),
        .DataWidth    (DW),
        .AddressWidth (AW)
    ) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .host_req_i           (host_req),
        .host_we_i            (host_we),
        .host_addr_i          (host_addr),
        .host_be_i            (host_be),
        .host_wdata_i         (host_wdata),
        .host_gnt_o           (host_gnt),
        .host_rvalid_o        (host_rvalid),
        .host_err_o           (host_err),
        .host_rdata_o         (host_rdata),
        .device_req_o         (device_req),
        .device_we_o          (device_we),
        .device_addr_o        (device_addr),
        .device_be_o          (device_be),
        .device_wdata_o       (device_wdata),
        .device_rvalid_i      (device_rvalid),
        .device_err_i         (device_err),
        .device_rdata_i       (device_rdata),
        .cfg_device_addr_base (cfg_base),
        .cfg_device_addr_mask (cfg_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NH-1:0] gnt_vec();
        logic [NH-1:0] v;
        for (int h = 0; h < NH; h++) v[h] = host_gnt[h];
        return v;
    endfunction

    function automatic logic [ND-1:0] dreq_vec();
        logic [ND-1:0] v;
        for (int d = 0; d < ND; d++) v[d] = device_req[d];
        return v;
    endfunction

    function automatic logic [NH*RW-1:0] resp_got();
        logic [NH*RW-1:0] v;
        for (int h = 0; h < NH; h++) v[h*RW +: RW] = {host_rvalid[h], host_err[h], host_rdata[h]};
        return v;
    endfunction

    function automatic logic [NH*RW-1:0] resp_exp(input exp_t e);
        logic [NH*RW-1:0] v;
        v = '0;
        v[e.host*RW +: RW] = {1'b1, e.err, e.rdata};
        return v;
    endfunction

    task automatic idle_hosts();
        for (int h = 0; h < NH; h++) begin
            host_req[h]   = 1'b0;
            host_we[h]    = 1'b0;
            host_addr[h]  = '0;
            host_be[h]    = '0;
            host_wdata[h] = '0;
        end
    endtask

    task automatic drive_host(input int h, input logic we, input logic [AW-1:0] addr,
                              input logic [DW/8-1:0] be, input logic [DW-1:0] wdata);
        host_req[h]   = 1'b1;
        host_we[h]    = we;
        host_addr[h]  = addr;
        host_be[h]    = be;
        host_wdata[h] = wdata;
    endtask

    // Advance one clock; devices that saw req answer in the following cycle.
    task automatic step();
        logic r[ND];
        for (int d = 0; d < ND; d++) r[d] = device_req[d];
        @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            device_rvalid[d] = r[d];
            device_rdata[d]  = r[d] ? dev_data[d] : '0;
            device_err[d]    = r[d] ? dev_err[d] : 1'b0;
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (resp_got() !== '0) begin bad++; $display("FAIL reset_resp: got %h want 0", resp_got()); end
        total++;
        if ({gnt_vec(), dreq_vec()} !== '0) begin bad++; $display("FAIL reset_gnt_req: got %b want 0", {gnt_vec(), dreq_vec()}); end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (resp_got() !== '0) begin bad++; $display("FAIL post_reset_resp: got %h want 0", resp_got()); end
        step();
    endtask

    task automatic test_read();
        exp_t e;
        drive_host(0, 1'b0, 32'h0010_0010, 4'hF, '0);
        sb.push_back('{host: 0, rdata: 32'hDEAD_BEEF, err: 1'b0});
        @(negedge clk);
        total++;
        if (gnt_vec() !== 2'b01) begin bad++; $display("FAIL read_gnt: got %b want 01", gnt_vec()); end
        total++;
        if (dreq_vec() !== 3'b001) begin bad++; $display("FAIL read_dreq: got %b want 001", dreq_vec()); end
        step();
        idle_hosts();
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL read_resp: scoreboard empty"); end
        else begin
            e = sb.pop_front();
            if (resp_got() !== resp_exp(e)) begin bad++; $display("FAIL read_resp: got %h want %h", resp_got(), resp_exp(e)); end
        end
        total++;
        if (gnt_vec() !== 2'b00) begin bad++; $display("FAIL idle_gnt: got %b want 00", gnt_vec()); end
        step();
    endtask

    task automatic test_write();
        exp_t e;
        drive_host(0, 1'b1, 32'h0002_0000, 4'hF, 32'h0000_0041);
        sb.push_back('{host: 0, rdata: 32'h0000_1111, err: 1'b0});
        @(negedge clk);
        total++;
        if (dreq_vec() !== 3'b010) begin bad++; $display("FAIL write_dreq: got %b want 010", dreq_vec()); end
        total++;
        if ({device_we[1], device_be[1], device_wdata[1]} !== {1'b1, 4'hF, 32'h0000_0041}) begin
            bad++;
            $display("FAIL write_fields: got we=%b be=%h wdata=%h want we=1 be=f wdata=00000041",
                     device_we[1], device_be[1], device_wdata[1]);
        end
        step();
        idle_hosts();
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL write_resp: scoreboard empty"); end
        else begin
            e = sb.pop_front();
            if (resp_got() !== resp_exp(e)) begin bad++; $display("FAIL write_resp: got %h want %h", resp_got(), resp_exp(e)); end
        end
        step();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        drive_host(0, 1'b0, 32'h0010_0020, 4'hF, '0);
        drive_host(1, 1'b0, 32'h0003_0004, 4'hF, '0);
        sb.push_back('{host: 0, rdata: 32'hDEAD_BEEF, err: 1'b0});
        @(negedge clk);
        total++;
        if ({gnt_vec(), dreq_vec()} !== 5'b01_001) begin bad++; $display("FAIL b2b_first: got %b want 01001", {gnt_vec(), dreq_vec()}); end
        step();
        host_req[0] = 1'b0;
        sb.push_back('{host: 1, rdata: 32'h7100_0000, err: 1'b0});
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL b2b_resp0: scoreboard empty"); end
        else begin
            e = sb.pop_front();
            if (resp_got() !== resp_exp(e)) begin bad++; $display("FAIL b2b_resp0: got %h want %h", resp_got(), resp_exp(e)); end
        end
        total++;
        if ({gnt_vec(), dreq_vec()} !== 5'b10_100) begin bad++; $display("FAIL b2b_second: got %b want 10100", {gnt_vec(), dreq_vec()}); end
        step();
        idle_hosts();
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL b2b_resp1: scoreboard empty"); end
        else begin
            e = sb.pop_front();
            if (resp_got() !== resp_exp(e)) begin bad++; $display("FAIL b2b_resp1: got %h want %h", resp_got(), resp_exp(e)); end
        end
        step();
    endtask

    task automatic test_dev_err();
        exp_t e;
        dev_err[2] = 1'b1;
        drive_host(1, 1'b0, 32'h0003_0000, 4'hF, '0);
        sb.push_back('{host: 1, rdata: 32'h7100_0000, err: 1'b1});
        @(negedge clk);
        total++;
        if ({gnt_vec(), dreq_vec()} !== 5'b10_100) begin bad++; $display("FAIL err_gnt: got %b want 10100", {gnt_vec(), dreq_vec()}); end
        step();
        idle_hosts();
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL err_resp: scoreboard empty"); end
        else begin
            e = sb.pop_front();
            if (resp_got() !== resp_exp(e)) begin bad++; $display("FAIL err_resp: got %h want %h", resp_got(), resp_exp(e)); end
        end
        dev_err[2] = 1'b0;
        step();
    endtask

`ifdef BUS_DECODE_ERR_EN
    task automatic test_unmapped();
        exp_t e;
        drive_host(0, 1'b0, 32'h0004_0000, 4'hF, '0);
        sb.push_back('{host: 0, rdata: 32'h0, err: 1'b1});
        @(negedge clk);
        total++;
        if ({gnt_vec(), dreq_vec()} !== 5'b01_000) begin bad++; $display("FAIL unmapped_gnt: got %b want 01000", {gnt_vec(), dreq_vec()}); end
        step();
        idle_hosts();
        @(negedge clk);
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL unmapped_resp: scoreboard empty"); end
        else begin
            e = sb.pop_front();
            if (resp_got() !== resp_exp(e)) begin bad++; $display("FAIL unmapped_resp: got %h want %h", resp_got(), resp_exp(e)); end
        end
        step();
    endtask
`endif

    task automatic test_reset_mid();
        drive_host(0, 1'b0, 32'h0010_0030, 4'hF, '0);
        @(negedge clk);
        total++;
        if (gnt_vec() !== 2'b01) begin bad++; $display("FAIL rstmid_gnt: got %b want 01", gnt_vec()); end
        step();
        // RAM is now driving rvalid for the pending read; reset must suppress it.
        rst_n = 1'b0;
        idle_hosts();
        #1;
        total++;
        if (resp_got() !== '0) begin bad++; $display("FAIL rstmid_resp: got %h want 0", resp_got()); end
        @(negedge clk);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({resp_got(), gnt_vec(), dreq_vec()} !== '0) begin bad++; $display("FAIL rstmid_after: got %h want 0", {resp_got(), gnt_vec(), dreq_vec()}); end
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_hosts();
        for (int d = 0; d < ND; d++) begin
            device_rvalid[d] = 1'b0;
            device_err[d]    = 1'b0;
            device_rdata[d]  = '0;
            dev_err[d]       = 1'b0;
        end
        cfg_base[0] = 32'h0010_0000; cfg_mask[0] = 32'hFFF0_0000;
        cfg_base[1] = 32'h0002_0000; cfg_mask[1] = 32'hFFFF_FC00;
        cfg_base[2] = 32'h0003_0000; cfg_mask[2] = 32'hFFFF_FC00;
        dev_data[0] = 32'hDEAD_BEEF;
        dev_data[1] = 32'h0000_1111;
        dev_data[2] = 32'h7100_0000;

        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_dev_err();
`ifdef BUS_DECODE_ERR_EN
        test_unmapped();
`endif
        test_reset_mid();

        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d left want 0", sb.size()); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
